// File: rtl/testsig_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// testsig_gen
//
// Programmable test-signal generator for the frequency-meter bench. A period
// counter running on sysclk produces a rectangular wave on sigout. Each period
// lasts P cycles: high for the first H cycles, then low. P and H come either
// from one of four presets (selected by testmode, H = P/2) or from a custom
// register pair loaded through a valid/ready handshake. New settings only take
// effect at period boundaries, so the output never carries a truncated pulse.
// A run is either a finite burst of burst_len periods or continuous
// (burst_len = 0). A continuous run ends after a stop request, once the current
// period has completed.
//
// Parameters
//   CNT_W      width of the period/high-time counters
//   PRESET0..3 preset periods in sysclk cycles for testmode 00..11
//   BURST_W    width of the burst counter
//
// Ports
//   sysclk       single clock
//   reset        asynchronous, active-high reset
//   testmode     preset select, used when use_custom = 0
//   use_custom   1 selects the custom period/high-time registers
//   cfg_period   custom period offer (cycles)
//   cfg_high     custom high-time offer (cycles)
//   cfg_valid    custom config offer
//   cfg_ready    config slot free; low while a config waits for a boundary
//   burst_len    periods per run, 0 = continuous
//   start        one-cycle start request (ignored while running)
//   stop         one-cycle stop request (ignored while idle)
//   sigout       generated signal
//   period_tick  high during the last cycle of every period
//   busy         high while a run is in progress
//   done         one-cycle pulse when a run ends
// ---------------------------------------------------------------------------
module testsig_gen #(
  parameter int          CNT_W   = 24,
  parameter int unsigned PRESET0 = 32000,
  parameter int unsigned PRESET1 = 16000,
  parameter int unsigned PRESET2 = 2000000,
  parameter int unsigned PRESET3 = 8000,
  parameter int          BURST_W = 16
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [1:0]         testmode,
  input  logic               use_custom,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               stop,
  output logic               sigout,
  output logic               period_tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] PRESET0_C = CNT_W'(PRESET0);
  localparam logic [CNT_W-1:0] PRESET1_C = CNT_W'(PRESET1);
  localparam logic [CNT_W-1:0] PRESET2_C = CNT_W'(PRESET2);
  localparam logic [CNT_W-1:0] PRESET3_C = CNT_W'(PRESET3);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sigout_q, sigout_d;
  logic                 done_q, done_d;
  logic [BURST_W-1:0]   remain_q, remain_d;
  logic                 stop_q, stop_d;
  logic [1:0]           mode_q, mode_d;
  logic                 custom_sel_q, custom_sel_d;
  logic [CNT_W-1:0]     act_period_q, act_period_d;
  logic [CNT_W-1:0]     act_high_q, act_high_d;
  logic [CNT_W-1:0]     pend_period_q, pend_period_d;
  logic [CNT_W-1:0]     pend_high_q, pend_high_d;
  logic                 pend_q, pend_d;

  logic [CNT_W-1:0]     preset_period;
  logic [CNT_W-1:0]     eff_period;
  logic [CNT_W-1:0]     eff_high;
  logic [CNT_W-1:0]     period_last;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 at_boundary;
  logic [CNT_W-1:0]     cap_period;
  logic [CNT_W-1:0]     cap_high_raw;
  logic [CNT_W-1:0]     cap_high;
  logic                 cfg_fire;
  logic                 run_end;

  // Effective (P,H) for the period in progress. The mode bits and the custom
  // registers are only ever updated at boundaries while running, so this pair
  // stays constant across a whole period.
  always_comb begin
    preset_period = PRESET0_C;
    case (mode_q)
      2'b00:   preset_period = PRESET0_C;
      2'b01:   preset_period = PRESET1_C;
      2'b10:   preset_period = PRESET2_C;
      default: preset_period = PRESET3_C;
    endcase
    eff_period  = custom_sel_q ? act_period_q : preset_period;
    eff_high    = custom_sel_q ? act_high_q : (preset_period >> 1);
    period_last = eff_period - CNT_W'(1);
    cnt_inc     = cnt_q + CNT_W'(1);
    at_boundary = (cnt_q == period_last);
  end

  // Clamp an offered custom config so the output always toggles:
  // at least two cycles per period, at least one high and one low cycle.
  always_comb begin
    cap_period   = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
    cap_high_raw = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
    cap_high     = (cap_high_raw >= cap_period) ? (cap_period - CNT_W'(1))
                                                : cap_high_raw;
  end

  // The config slot is free unless a value is waiting for the next boundary.
  assign cfg_ready = ~pend_q;
  assign cfg_fire  = cfg_valid & cfg_ready;

  // Next-state logic. In IDLE the mode inputs and custom offers go straight to
  // the active registers, so a handshake on the start edge already shapes the
  // first period. In RUN everything that changes the waveform is deferred to
  // the boundary edge (cnt = P-1); a run that ends there drops any pending
  // config instead of applying it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sigout_d      = sigout_q;
    done_d        = 1'b0;
    remain_d      = remain_q;
    stop_d        = stop_q;
    mode_d        = mode_q;
    custom_sel_d  = custom_sel_q;
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    pend_d        = pend_q;
    run_end       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mode_d       = testmode;
        custom_sel_d = use_custom;
        cnt_d        = '0;
        sigout_d     = 1'b0;
        stop_d       = 1'b0;
        pend_d       = 1'b0;
        if (cfg_fire) begin
          act_period_d = cap_period;
          act_high_d   = cap_high;
        end
        if (start) begin
          state_d  = ST_RUN;
          remain_d = burst_len;
          cnt_d    = '0;
          sigout_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (!at_boundary) begin
          cnt_d    = cnt_inc;
          sigout_d = (cnt_inc < eff_high);
          if (stop) begin
            stop_d = 1'b1;
          end
          if (cfg_fire) begin
            pend_period_d = cap_period;
            pend_high_d   = cap_high;
            pend_d        = 1'b1;
          end
        end else begin
          cnt_d   = '0;
          run_end = (remain_q == BURST_W'(1)) | stop_q | stop;
          if (remain_q != '0) begin
            remain_d = remain_q - BURST_W'(1);
          end
          if (run_end) begin
            state_d  = ST_IDLE;
            sigout_d = 1'b0;
            done_d   = 1'b1;
            pend_d   = 1'b0;
            stop_d   = 1'b0;
          end else begin
            sigout_d     = 1'b1;
            mode_d       = testmode;
            custom_sel_d = use_custom;
            if (pend_q) begin
              act_period_d = pend_period_q;
              act_high_d   = pend_high_q;
              pend_d       = 1'b0;
            end else if (cfg_fire) begin
              pend_period_d = cap_period;
              pend_high_d   = cap_high;
              pend_d        = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Reset leaves the custom registers at the smallest legal
  // waveform (P=2, H=1) so selecting custom mode without a handshake is safe.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sigout_q      <= 1'b0;
      done_q        <= 1'b0;
      remain_q      <= '0;
      stop_q        <= 1'b0;
      mode_q        <= 2'b00;
      custom_sel_q  <= 1'b0;
      act_period_q  <= CNT_W'(2);
      act_high_q    <= CNT_W'(1);
      pend_period_q <= '0;
      pend_high_q   <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sigout_q      <= sigout_d;
      done_q        <= done_d;
      remain_q      <= remain_d;
      stop_q        <= stop_d;
      mode_q        <= mode_d;
      custom_sel_q  <= custom_sel_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      pend_q        <= pend_d;
    end
  end

  // period_tick is combinational so that it drops together with busy when
  // reset is asserted, without waiting for a clock edge.
  assign busy        = (state_q == ST_RUN);
  assign period_tick = busy & at_boundary;
  assign sigout      = sigout_q;
  assign done        = done_q;

endmodule

// File: tb/tb_testsig_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_testsig_gen
//
// Self-checking bench for testsig_gen. A behavioural model tracks the run as
// "which period are we in, how far into it, and what (P,H) governs it" using
// plain integers; a compare process checks every DUT output against it on
// every falling edge. Directed sequences add hand-computed expectations at
// known cycle offsets from each start edge.
// ---------------------------------------------------------------------------
module tb_testsig_gen;

  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;

  logic               sysclk = 1'b0;
  logic               reset;
  logic [1:0]         testmode = 2'b00;
  logic               use_custom = 1'b0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic [CNT_W-1:0]   cfg_high = '0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [BURST_W-1:0] burst_len = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               sigout;
  logic               period_tick;
  logic               busy;
  logic               done;

  int checks = 0;
  int fails  = 0;

  testsig_gen #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .testmode    (testmode),
    .use_custom  (use_custom),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .burst_len   (burst_len),
    .start       (start),
    .stop        (stop),
    .sigout      (sigout),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ...
  always #5 sysclk = ~sysclk;

  // Behavioural model state: run flag, offset into the current period, the
  // period's length and high time, periods still to go, and the custom config.
  int presetTab[4] = '{32000, 16000, 2000000, 8000};
  bit mRun     = 1'b0;
  int mPhase   = 0;
  int mPer     = 2;
  int mHi      = 1;
  int mLeft    = 0;
  bit mStopReq = 1'b0;
  int mCustPer = 2;
  int mCustHi  = 1;
  bit mPend    = 1'b0;
  int mPendPer = 0;
  int mPendHi  = 0;
  bit mDone    = 1'b0;

  function automatic int clampPer(int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int clampHi(int p, int h);
    int pp;
    int hh;
    pp = clampPer(p);
    hh = (h == 0) ? 1 : h;
    if (hh >= pp) hh = pp - 1;
    return hh;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  always @(posedge sysclk or posedge reset) begin : modelUpdate
    int cp;
    int ch;
    if (reset) begin
      mRun     <= 1'b0;
      mPhase   <= 0;
      mLeft    <= 0;
      mStopReq <= 1'b0;
      mCustPer <= 2;
      mCustHi  <= 1;
      mPend    <= 1'b0;
      mDone    <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (!mRun) begin
        cp = mCustPer;
        ch = mCustHi;
        if (cfg_valid) begin
          cp = clampPer(int'(cfg_period));
          ch = clampHi(int'(cfg_period), int'(cfg_high));
        end
        mCustPer <= cp;
        mCustHi  <= ch;
        if (start) begin
          mRun     <= 1'b1;
          mPhase   <= 0;
          mLeft    <= int'(burst_len);
          mStopReq <= 1'b0;
          mPer     <= use_custom ? cp : presetTab[testmode];
          mHi      <= use_custom ? ch : presetTab[testmode] / 2;
        end
      end else if (mPhase == mPer - 1) begin
        if ((mLeft == 1) || mStopReq || stop) begin
          mRun     <= 1'b0;
          mDone    <= 1'b1;
          mPend    <= 1'b0;
          mStopReq <= 1'b0;
          mPhase   <= 0;
        end else begin
          cp = mCustPer;
          ch = mCustHi;
          if (mPend) begin
            cp = mPendPer;
            ch = mPendHi;
            mPend <= 1'b0;
          end else if (cfg_valid) begin
            mPendPer <= clampPer(int'(cfg_period));
            mPendHi  <= clampHi(int'(cfg_period), int'(cfg_high));
            mPend    <= 1'b1;
          end
          mCustPer <= cp;
          mCustHi  <= ch;
          if (mLeft > 0) mLeft <= mLeft - 1;
          mPhase <= 0;
          mPer   <= use_custom ? cp : presetTab[testmode];
          mHi    <= use_custom ? ch : presetTab[testmode] / 2;
        end
      end else begin
        mPhase <= mPhase + 1;
        if (stop) mStopReq <= 1'b1;
        if (cfg_valid && !mPend) begin
          mPendPer <= clampPer(int'(cfg_period));
          mPendHi  <= clampHi(int'(cfg_period), int'(cfg_high));
          mPend    <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge sysclk) begin
    checkOutput("model_sigout", sigout, mRun && (mPhase < mHi));
    checkOutput("model_tick", period_tick, mRun && (mPhase == mPer - 1));
    checkOutput("model_busy", busy, mRun);
    checkOutput("model_done", done, mDone);
    checkOutput("model_cfg_ready", cfg_ready, !mPend);
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Drive one cycle of requests; returns 1 ns after the edge that sampled them.
  task automatic applyStimulus(input logic st, input logic sp, input logic cv,
                               input int per, input int hi);
    start      = st;
    stop       = sp;
    cfg_valid  = cv;
    cfg_period = CNT_W'(per);
    cfg_high   = CNT_W'(hi);
    step(1);
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_sigout", sigout, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_tick", period_tick, 1'b0);
    checkOutput("rst_cfg_ready", cfg_ready, 1'b1);
    step(2);
    reset = 1'b0;
    step(1);

    $display("[TB] custom burst P=10 H=3 x4");
    use_custom = 1'b1;
    burst_len  = 16'd4;
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 3);
    checkOutput("idle_cfg_ready", cfg_ready, 1'b1);
    checkOutput("idle_busy", busy, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    checkOutput("burst_start_sigout", sigout, 1'b1);
    checkOutput("burst_start_busy", busy, 1'b1);
    for (int k = 1; k <= 41; k++) begin
      step(1);
      if (k == 2)  checkOutput("burst_high_end", sigout, 1'b1);
      if (k == 3)  checkOutput("burst_low_start", sigout, 1'b0);
      if (k == 9)  checkOutput("burst_tick", period_tick, 1'b1);
      if (k == 32) checkOutput("burst_p4_high", sigout, 1'b1);
      if (k == 40) begin
        checkOutput("burst_done", done, 1'b1);
        checkOutput("burst_done_busy", busy, 1'b0);
        checkOutput("burst_done_sigout", sigout, 1'b0);
      end
      if (k == 41) checkOutput("burst_done_pulse", done, 1'b0);
    end

    $display("[TB] mid-run reconfigure to P=6 H=2");
    burst_len = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    step(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 6, 2);
    checkOutput("reconf_ready_low", cfg_ready, 1'b0);
    step(4);
    checkOutput("reconf_old_tick", period_tick, 1'b1);
    checkOutput("reconf_ready_wait", cfg_ready, 1'b0);
    step(1);
    checkOutput("reconf_ready_back", cfg_ready, 1'b1);
    checkOutput("reconf_new_sigout0", sigout, 1'b1);
    step(1);
    checkOutput("reconf_new_sigout1", sigout, 1'b1);
    step(1);
    checkOutput("reconf_new_sigout2", sigout, 1'b0);
    step(3);
    checkOutput("reconf_new_tick", period_tick, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("reconf_stop_done", done, 1'b1);
    step(1);

    $display("[TB] clamping");
    burst_len = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b1, 1, 0);
    checkOutput("clamp1_sigout0", sigout, 1'b1);
    step(1);
    checkOutput("clamp1_sigout1", sigout, 1'b0);
    checkOutput("clamp1_tick", period_tick, 1'b1);
    step(1);
    checkOutput("clamp1_sigout2", sigout, 1'b1);
    checkOutput("clamp1_busy", busy, 1'b1);
    step(2);
    checkOutput("clamp1_done", done, 1'b1);
    step(1);
    burst_len = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b1, 10, 12);
    step(8);
    checkOutput("clamp2_high8", sigout, 1'b1);
    step(1);
    checkOutput("clamp2_low9", sigout, 1'b0);
    checkOutput("clamp2_tick", period_tick, 1'b1);
    step(1);
    checkOutput("clamp2_done", done, 1'b1);
    checkOutput("clamp2_busy", busy, 1'b0);
    step(1);

    $display("[TB] stop mid-period with repeated start");
    burst_len = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b1, 10, 3);
    step(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    checkOutput("stop_busy", busy, 1'b1);
    checkOutput("stop_no_done", done, 1'b0);
    step(6);
    checkOutput("stop_tick", period_tick, 1'b1);
    checkOutput("stop_still_busy", busy, 1'b1);
    step(1);
    checkOutput("stop_done", done, 1'b1);
    checkOutput("stop_idle", busy, 1'b0);
    checkOutput("stop_sigout", sigout, 1'b0);
    step(2);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b1, 10, 7);
    step(5);
    checkOutput("rmid_sigout_pre", sigout, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rmid_sigout", sigout, 1'b0);
    checkOutput("rmid_busy", busy, 1'b0);
    checkOutput("rmid_tick", period_tick, 1'b0);
    checkOutput("rmid_cfg_ready", cfg_ready, 1'b1);
    #2 reset = 1'b0;
    step(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    checkOutput("rmid_restart_sigout", sigout, 1'b1);
    checkOutput("rmid_restart_tick", period_tick, 1'b0);
    step(1);
    checkOutput("rmid_default_tick", period_tick, 1'b1);
    checkOutput("rmid_default_low", sigout, 1'b0);
    step(1);
    checkOutput("rmid_default_high", sigout, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("rmid_stop_tick", period_tick, 1'b1);
    step(1);
    checkOutput("rmid_stop_done", done, 1'b1);
    step(1);

    $display("[TB] preset run, testmode change mid-period");
    use_custom = 1'b0;
    testmode   = 2'b00;
    burst_len  = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    checkOutput("preset_start_sigout", sigout, 1'b1);
    step(100);
    testmode = 2'b11;
    step(15899);
    checkOutput("preset_high_last", sigout, 1'b1);
    step(1);
    checkOutput("preset_low_first", sigout, 1'b0);
    step(15999);
    checkOutput("preset_tick", period_tick, 1'b1);
    step(1);
    checkOutput("preset_p2_sigout", sigout, 1'b1);
    checkOutput("preset_p2_tick", period_tick, 1'b0);
    checkOutput("preset_p2_busy", busy, 1'b1);
    step(3999);
    checkOutput("mode3_high_last", sigout, 1'b1);
    step(1);
    checkOutput("mode3_low_first", sigout, 1'b0);
    step(3999);
    checkOutput("mode3_tick", period_tick, 1'b1);
    step(1);
    checkOutput("mode3_p3_busy", busy, 1'b1);
    checkOutput("mode3_p3_tick", period_tick, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("preset_rst_busy", busy, 1'b0);
    #2 reset = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
